// File: rtl/led_step_seq.sv
// led_step_seq: programmable-rate 3-bit index generator feeding a 3-to-8
// LED decoder. A prescaler counts CNT_MAX sys_clk cycles per index step;
// start/stop/clear drive a small IDLE/RUN/PAUSE controller.
// Optional ping-pong sequencing is compiled in with LED_STEP_BOUNCE_EN.
module led_step_seq #(
    parameter int CNT_MAX = 25_000_000,
    parameter int CNT_W   = 25
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic start,
    input  logic stop,
    input  logic clear,
    input  logic dir_up,
    input  logic bounce,
    output logic in1,
    output logic in2,
    output logic in3,
    output logic step_pulse,
    output logic running
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [2:0]       idx_step;
    logic             counting;
    logic             wrap;

    // Controller next state: clear wins, start+stop together is a no-op,
    // otherwise start resumes from IDLE/PAUSE and stop pauses RUN.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch.
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else if (start && stop) begin
            state_nxt = state;
        end else if (start && state != S_RUN) begin
            state_nxt = S_RUN;
        end else if (stop && state == S_RUN) begin
            state_nxt = S_PAUSE;
        end
    end

    // The prescaler only advances on edges that keep us in RUN, so the edge
    // that accepts a stop freezes cnt and resume continues from the held value.
    assign counting = (state == S_RUN) && (state_nxt == S_RUN);
    assign wrap     = counting && (cnt == CNT_LAST);

`ifdef LED_STEP_BOUNCE_EN
    logic bdir_up;
    logic bdir_nxt;

    // Next index: ping-pong reverses at 7 and 0 so each endpoint shows once.
    always_comb begin
        idx_step = idx;
        bdir_nxt = bdir_up;
        if (bounce) begin
            if (bdir_up) begin
                if (idx == 3'd7) begin
                    idx_step = 3'd6;
                    bdir_nxt = 1'b0;
                end else begin
                    idx_step = idx + 3'd1;
                end
            end else begin
                if (idx == 3'd0) begin
                    idx_step = 3'd1;
                    bdir_nxt = 1'b1;
                end else begin
                    idx_step = idx - 3'd1;
                end
            end
        end else begin
            idx_step = dir_up ? idx + 3'd1 : idx - 3'd1;
        end
    end

    // Bounce direction register: up after reset/clear, flips only on a step.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bdir_up <= 1'b1;
        end else if (clear) begin
            bdir_up <= 1'b1;
        end else if (wrap) begin
            bdir_up <= bdir_nxt;
        end
    end
`else
    logic unused_bounce;
    assign unused_bounce = bounce;

    // Next index: plain 3-bit modulo up/down count.
    always_comb begin
        idx_step = dir_up ? idx + 3'd1 : idx - 3'd1;
    end
`endif

    // State, prescaler, index and the registered status outputs.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            step_pulse <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            running    <= (state_nxt == S_RUN);
            step_pulse <= wrap;
            if (clear) begin
                cnt <= '0;
                idx <= 3'd0;
            end else if (wrap) begin
                cnt <= '0;
                idx <= idx_step;
            end else if (counting) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign {in1, in2, in3} = idx;

endmodule
